crc16_tx_framer: RTL and testbench

Transmit framer placed directly upstream of the bit-serial CRC-16 engine (poly 0x1021, preset 0xFFFF, MSB-first). It accepts a byte stream with a valid/ready handshake and serializes each byte MSB-first onto a paced bit output. It drives the engine's reload, valid, data and shift controls, then appends the 16-bit CRC taken from the engine register. The result is one complete bit frame (payload followed by CRC) for the modulator.

---
 rtl/crc16_tx_framer.sv | 169 ++++++++++++++++
 tb/tb_crc16_tx_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_tx_framer.sv
// Byte-stream to bit-serial framer: drives a bit-serial CRC-16 engine and appends its CRC after the payload.
// Build option: define CRC16_TX_INVERT_EN to transmit the CRC ones-complemented (CRC-16/GENIBUS).
module crc16_tx_framer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_bit,
    output logic        o_bit_valid,
    input  logic        i_bit_ready,
    output logic        o_crc_reload,
    output logic        o_crc_valid,
    output logic        o_crc_data,
    output logic        o_crc_shift,
    input  logic [15:0] i_crc,
    output logic        o_busy,
    output logic        o_frame_done
);

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_e;

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        shift_full_q;
    logic        cur_last_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic        hold_last_q;
    logic        last_seen_q;
    logic [3:0]  crc_cnt_q;
    logic        armed_q;
    logic        frame_done_q;

    logic        accept;
    logic        xfer;
    logic        crc_bit;
    logic        unused_crc;

    // Only the engine's MSB is ever observed; the remaining bits shift up into it.
    assign unused_crc = ^i_crc[14:0];

`ifdef CRC16_TX_INVERT_EN
    assign crc_bit = ~i_crc[15];
`else
    assign crc_bit = i_crc[15];
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        o_byte_ready = 1'b0;
        o_bit        = 1'b0;
        o_bit_valid  = 1'b0;
        case (state_q)
            IDLE: o_byte_ready = armed_q;
            DATA: begin
                o_byte_ready = !hold_full_q && !last_seen_q;
                o_bit        = shift_q[7];
                o_bit_valid  = shift_full_q;
            end
            CRC: begin
                o_bit       = crc_bit;
                o_bit_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept       = i_byte_valid && o_byte_ready;
    assign xfer         = o_bit_valid && i_bit_ready;
    assign o_crc_reload = (state_q == IDLE) && accept;
    assign o_crc_valid  = xfer;
    assign o_crc_data   = xfer && (state_q == DATA) && shift_q[7];
    assign o_crc_shift  = xfer && (state_q == CRC);
    assign o_busy       = (state_q == DATA) || (state_q == CRC);
    assign o_frame_done = frame_done_q;

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            shift_full_q <= 1'b0;
            cur_last_q   <= 1'b0;
            hold_q       <= 8'h00;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            last_seen_q  <= 1'b0;
            crc_cnt_q    <= 4'd0;
            armed_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            frame_done_q <= 1'b0;
            if (accept && i_byte_last) begin
                last_seen_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q      <= i_byte;
                        cur_last_q   <= i_byte_last;
                        shift_full_q <= 1'b1;
                        bit_cnt_q    <= 3'd0;
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Byte boundary: refill from the holding register, the source, or finish payload.
                            if (hold_full_q) begin
                                shift_q     <= hold_q;
                                cur_last_q  <= hold_last_q;
                                hold_full_q <= 1'b0;
                            end else if (cur_last_q) begin
                                shift_full_q <= 1'b0;
                                crc_cnt_q    <= 4'd0;
                                state_q      <= CRC;
                            end else if (accept) begin
                                shift_q    <= i_byte;
                                cur_last_q <= i_byte_last;
                            end else begin
                                shift_full_q <= 1'b0;
                            end
                        end else if (accept) begin
                            hold_q      <= i_byte;
                            hold_last_q <= i_byte_last;
                            hold_full_q <= 1'b1;
                        end
                    end else if (accept) begin
                        if (shift_full_q) begin
                            hold_q      <= i_byte;
                            hold_last_q <= i_byte_last;
                            hold_full_q <= 1'b1;
                        end else begin
                            shift_q      <= i_byte;
                            cur_last_q   <= i_byte_last;
                            shift_full_q <= 1'b1;
                        end
                    end
                end
                CRC: begin
                    if (xfer) begin
                        crc_cnt_q <= crc_cnt_q + 4'd1;
                        if (crc_cnt_q == 4'd15) begin
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    last_seen_q <= 1'b0;
                    cur_last_q  <= 1'b0;
                    hold_last_q <= 1'b0;
                    bit_cnt_q   <= 3'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_tx_framer.sv
// Directed bench for crc16_tx_framer: a behavioural CRC-16 engine feeds i_crc, frames are captured bit by bit
// and compared against hand-computed payload/CRC values; multi-cycle corners are exercised as hand-written sequences.
module tb_crc16_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_byte_last;
    logic        o_byte_ready;
    logic        o_bit;
    logic        o_bit_valid;
    logic        i_bit_ready;
    logic        o_crc_reload;
    logic        o_crc_valid;
    logic        o_crc_data;
    logic        o_crc_shift;
    logic [15:0] i_crc;
    logic        o_busy;
    logic        o_frame_done;

    always #5 clk = ~clk;

    crc16_tx_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_byte_last  (i_byte_last),
        .o_byte_ready (o_byte_ready),
        .o_bit        (o_bit),
        .o_bit_valid  (o_bit_valid),
        .i_bit_ready  (i_bit_ready),
        .o_crc_reload (o_crc_reload),
        .o_crc_valid  (o_crc_valid),
        .o_crc_data   (o_crc_data),
        .o_crc_shift  (o_crc_shift),
        .i_crc        (i_crc),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    // Bit-serial CRC-16 engine (poly 0x1021, MSB-first); not tied to rst_n, resynced by reload.
    logic [15:0] crc_m = 16'h0000;
    always @(posedge clk) begin
        if (o_crc_reload)
            crc_m <= 16'hFFFF;
        else if (o_crc_valid) begin
            if (o_crc_shift)
                crc_m <= {crc_m[14:0], 1'b0};
            else
                crc_m <= {crc_m[14:0], 1'b0} ^ ((crc_m[15] ^ o_crc_data) ? 16'h1021 : 16'h0000);
        end
    end
    assign i_crc = crc_m;

    typedef struct packed {
        int          mode;       // 0: bit_ready high, 1: random bit_ready, 2: source starved after byte 3
        int          n;
        logic [71:0] data;       // byte 0 in bits [71:64]
        logic [15:0] crc;        // CRC-16/CCITT-FALSE of the payload
        int          stall;
        bit          chk_ready_low;
        bit          chk_b2b;
        bit          chk_chain;
    } vec_t;

    vec_t vecs [5];

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0;
    bit rnd_mode = 1'b0;
    bit last_accept;
    bit rx [$];
    int acc_q [$];
    int first_t, t0, t_done, fd_count, stall_cnt;
    int cv_viol, reload_viol, hold_viol, busy_viol, rdy_in_frame;
    bit in_frame = 1'b0;
    bit prev_hold = 1'b0;
    bit prev_bit = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic int wire_crc(input logic [15:0] c);
`ifdef CRC16_TX_INVERT_EN
        return int'(~c);
`else
        return int'(c);
`endif
    endfunction

    function automatic int rx_bits(input int start, input int len);
        int v;
        v = 0;
        for (int k = 0; k < len; k++)
            v = (v << 1) | ((start + k < rx.size()) ? int'(rx[start + k]) : 0);
        return v;
    endfunction

    task automatic clear_mon();
        rx.delete();
        acc_q.delete();
        first_t = -1; t0 = -1; t_done = -1;
        fd_count = 0; stall_cnt = 0;
        cv_viol = 0; reload_viol = 0; hold_viol = 0; busy_viol = 0; rdy_in_frame = 0;
    endtask

    task automatic monitor();
        bit xfer, acc, was_in;
        last_accept = 1'b0;
        if (!rst_n) begin
            prev_hold = 1'b0;
            in_frame  = 1'b0;
            return;
        end
        xfer   = o_bit_valid && i_bit_ready;
        acc    = o_byte_ready && i_byte_valid;
        was_in = in_frame;
        last_accept = acc;
        if (o_crc_valid !== xfer) cv_viol++;
        if (o_crc_reload !== (acc && !was_in)) reload_viol++;
        if (prev_hold && !(o_bit_valid && (o_bit == prev_bit))) hold_viol++;
        prev_hold = o_bit_valid && !i_bit_ready;
        prev_bit  = o_bit;
        if (xfer) begin
            rx.push_back(o_bit);
            if (first_t < 0) first_t = cyc;
        end
        if (acc) begin
            if (!was_in) begin
                in_frame = 1'b1;
                t0 = cyc;
            end
            acc_q.push_back(cyc);
        end
        if (was_in && o_byte_ready) rdy_in_frame++;
        if (o_busy && !o_bit_valid) stall_cnt++;
        if (was_in && !o_frame_done && !o_busy) busy_viol++;
        if (o_frame_done) begin
            fd_count++;
            t_done = cyc;
            in_frame = 1'b0;
        end
    endtask

    // One clock: sample on the falling edge, then move to just after the rising edge for new stimulus.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_mode) i_bit_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input string name);
        bit got;
        got = 1'b0;
        i_byte       = b;
        i_byte_last  = last;
        i_byte_valid = 1'b1;
        for (int w = 0; w < 400 && !got; w++) begin
            step();
            got = last_accept;
        end
        check(name, int'(got), 1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   prev_done;
        int   a1, a2;
        v = vecs[idx];
        prev_done = t_done;
        clear_mon();
        rnd_mode = (v.mode == 1);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.data[71 - 8*i -: 8], (i == v.n - 1), $sformatf("v%0d_accept%0d", idx, i));
            if (v.mode == 2 && i == 3) begin
                i_byte_valid = 1'b0;
                for (int w = 0; w < 100 && stall_cnt == 0; w++) step();
                repeat (3) step();
            end
        end
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        for (int w = 0; w < 3000 && fd_count == 0; w++) step();
        rnd_mode    = 1'b0;
        i_bit_ready = 1'b1;

        check($sformatf("v%0d_frame_done_count", idx), fd_count, 1);
        check($sformatf("v%0d_nbits", idx), rx.size(), 8*v.n + 16);
        for (int i = 0; i < v.n; i++)
            check($sformatf("v%0d_payload_byte%0d", idx, i), rx_bits(8*i, 8), int'(v.data[71 - 8*i -: 8]));
        check($sformatf("v%0d_crc", idx), rx_bits(8*v.n, 16), wire_crc(v.crc));
        check($sformatf("v%0d_crc_valid_viol", idx), cv_viol, 0);
        check($sformatf("v%0d_reload_viol", idx), reload_viol, 0);
        check($sformatf("v%0d_hold_stable_viol", idx), hold_viol, 0);
        check($sformatf("v%0d_busy_viol", idx), busy_viol, 0);
        if (v.mode != 1) begin
            check($sformatf("v%0d_first_bit_latency", idx), first_t - t0, 1);
            check($sformatf("v%0d_done_latency", idx), t_done - t0, 8*v.n + 17 + v.stall);
            check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.stall);
        end
        if (v.chk_ready_low)
            check($sformatf("v%0d_ready_high_in_frame", idx), rdy_in_frame, 0);
        if (v.chk_b2b) begin
            a1 = (acc_q.size() > 1) ? acc_q[1] - t0 : -1;
            a2 = (acc_q.size() > 2) ? acc_q[2] - t0 : -1;
            check($sformatf("v%0d_byte1_accept_cycle", idx), a1, 1);
            check($sformatf("v%0d_byte2_accept_cycle", idx), a2, 9);
        end
        if (v.chk_chain)
            check($sformatf("v%0d_accept_after_done", idx), t0 - prev_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mode: 0, n: 9, data: 72'h31_32_33_34_35_36_37_38_39, crc: 16'h29B1, stall: 0,
                    chk_ready_low: 1'b0, chk_b2b: 1'b1, chk_chain: 1'b0};
        vecs[1] = '{mode: 1, n: 9, data: 72'h31_32_33_34_35_36_37_38_39, crc: 16'h29B1, stall: 0,
                    chk_ready_low: 1'b0, chk_b2b: 1'b0, chk_chain: 1'b0};
        vecs[2] = '{mode: 2, n: 9, data: 72'h31_32_33_34_35_36_37_38_39, crc: 16'h29B1, stall: 5,
                    chk_ready_low: 1'b0, chk_b2b: 1'b0, chk_chain: 1'b0};
        vecs[3] = '{mode: 0, n: 1, data: {8'hA5, 64'h0}, crc: 16'h04BF, stall: 0,
                    chk_ready_low: 1'b1, chk_b2b: 1'b0, chk_chain: 1'b0};
        vecs[4] = '{mode: 0, n: 9, data: 72'h31_32_33_34_35_36_37_38_39, crc: 16'h29B1, stall: 0,
                    chk_ready_low: 1'b0, chk_b2b: 1'b0, chk_chain: 1'b1};

        rst_n        = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_bit_ready  = 1'b1;
        clear_mon();

        #12;
        check("reset_byte_ready", int'(o_byte_ready), 0);
        check("reset_bit_valid", int'(o_bit_valid), 0);
        check("reset_bit", int'(o_bit), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_frame_done", int'(o_frame_done), 0);
        check("reset_crc_ctrl", int'({o_crc_reload, o_crc_valid, o_crc_data, o_crc_shift}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(k);

        // Abort a frame with reset at bit 20.
        clear_mon();
        send_byte(8'h31, 1'b0, "rst_accept0");
        send_byte(8'h32, 1'b0, "rst_accept1");
        send_byte(8'h33, 1'b0, "rst_accept2");
        i_byte_valid = 1'b0;
        for (int w = 0; w < 200 && rx.size() < 20; w++) step();
        check("rst_bits_before_abort", rx.size(), 20);
        check("rst_busy_before_abort", int'(o_busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", int'(o_busy), 0);
        check("rst_async_bit_valid", int'(o_bit_valid), 0);
        check("rst_async_bit", int'(o_bit), 0);
        check("rst_async_byte_ready", int'(o_byte_ready), 0);
        check("rst_async_frame_done", int'(o_frame_done), 0);
        check("rst_async_crc_ctrl", int'({o_crc_reload, o_crc_valid, o_crc_data, o_crc_shift}), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check("rst_no_frame_done", fd_count, 0);
        check("rst_idle_ready", int'(o_byte_ready), 1);

        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
